vga_timing_gen: RTL and testbench

Parameterised VGA raster timing generator. It is the stage directly upstream of every pixel-art renderer in the design. It produces hsync/vsync, the active-video flag and the beam position that a renderer decodes into colour. It also adds line/frame strobes and a frame counter so downstream renderers can animate.

---
 rtl/vga_timing_gen.sv | 106 ++++++++++
 tb/tb_vga_timing_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parameterised VGA raster timing generator with line/frame strobes
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0,
    parameter int CLK_DIV   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = H_DISPLAY + H_FRONT + H_SYNC;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = V_DISPLAY + V_FRONT + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic SYNC_ACT = (SYNC_POL != 0);

    // Reject geometries the 10-bit position outputs cannot represent
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_div_check
            $error("vga_timing_gen: CLK_DIV must be within 1..4");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic [10:0]      h_ext;
    logic [10:0]      v_ext;

    assign tick  = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign h_ext = {1'b0, h_next};
    assign v_ext = {1'b0, v_next};

    // Next beam position; decode runs on this so outputs line up with hpos/vpos
    always_comb begin
        h_next = hpos + 10'd1;
        v_next = vpos;
        if (hpos == 10'(H_TOTAL - 1)) begin
            h_next = 10'd0;
            v_next = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
        end
    end

    // Pixel-rate divider; reset to the last phase so the first clk after reset is a tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= DIV_W'(CLK_DIV - 1);
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Beam counters, sync/active decode, one-clk strobes and frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos        <= 10'(H_TOTAL - 1);
            vpos        <= 10'(V_TOTAL - 1);
            hsync       <= ~SYNC_ACT;
            vsync       <= ~SYNC_ACT;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
        end else if (tick) begin
            hpos        <= h_next;
            vpos        <= v_next;
            hsync       <= (h_ext >= 11'(HS_START) && h_ext < 11'(HS_END)) ? SYNC_ACT : ~SYNC_ACT;
            vsync       <= (v_ext >= 11'(VS_START) && v_ext < 11'(VS_END)) ? SYNC_ACT : ~SYNC_ACT;
            display_on  <= (h_ext < 11'(H_DISPLAY)) && (v_ext < 11'(V_DISPLAY));
            line_start  <= (h_next == 10'd0);
            frame_start <= (h_next == 10'd0) && (v_next == 10'd0);
            if (h_next == 10'd0 && v_next == 10'd0) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end else begin
            // Strobes are one clk wide even when a pixel spans several clks
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen over three timing geometries
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       display_on;
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic       line_start;
        logic       frame_start;
        logic [7:0] frame_cnt;
    } obs_t;

    // H_DISPLAY, H_FRONT, H_SYNC, H_BACK, V_DISPLAY, V_FRONT, V_SYNC, V_BACK, SYNC_POL, CLK_DIV
    int cfg [3][10] = '{
        '{4, 1, 2, 1, 3, 1, 1, 1, 1, 1},
        '{8, 2, 3, 2, 4, 1, 2, 1, 0, 2},
        '{640, 16, 96, 48, 480, 10, 2, 33, 0, 1}
    };

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_c = 1'b0;
    int   total = 0;
    int   bad = 0;
    obs_t q_a [$];
    obs_t q_b [$];
    obs_t q_c [$];
    obs_t obs_a, obs_b, obs_c;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1), .CLK_DIV(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_a),
        .hsync(obs_a.hsync), .vsync(obs_a.vsync), .display_on(obs_a.display_on),
        .hpos(obs_a.hpos), .vpos(obs_a.vpos),
        .line_start(obs_a.line_start), .frame_start(obs_a.frame_start),
        .frame_cnt(obs_a.frame_cnt)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_POL(0), .CLK_DIV(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_b),
        .hsync(obs_b.hsync), .vsync(obs_b.vsync), .display_on(obs_b.display_on),
        .hpos(obs_b.hpos), .vpos(obs_b.vpos),
        .line_start(obs_b.line_start), .frame_start(obs_b.frame_start),
        .frame_cnt(obs_b.frame_cnt)
    );

    vga_timing_gen dut_c (
        .clk(clk), .rst_n(rst_c),
        .hsync(obs_c.hsync), .vsync(obs_c.vsync), .display_on(obs_c.display_on),
        .hpos(obs_c.hpos), .vpos(obs_c.vpos),
        .line_start(obs_c.line_start), .frame_start(obs_c.frame_start),
        .frame_cnt(obs_c.frame_cnt)
    );

    // Expected outputs k clks after reset release (k=0: held in reset), from absolute pixel index
    function automatic obs_t model(input int i, input int k);
        obs_t e;
        int hd, hf, hs, vd, vf, vs, ht, vt, div, p, ph, h, v, f;
        logic act;
        hd = cfg[i][0]; hf = cfg[i][1]; hs = cfg[i][2];
        vd = cfg[i][4]; vf = cfg[i][5]; vs = cfg[i][6];
        ht = cfg[i][0] + cfg[i][1] + cfg[i][2] + cfg[i][3];
        vt = cfg[i][4] + cfg[i][5] + cfg[i][6] + cfg[i][7];
        act = (cfg[i][8] != 0);
        div = cfg[i][9];
        if (k == 0) begin
            e.hsync = ~act; e.vsync = ~act; e.display_on = 1'b0;
            e.hpos = 10'(ht - 1); e.vpos = 10'(vt - 1);
            e.line_start = 1'b0; e.frame_start = 1'b0; e.frame_cnt = 8'd0;
        end else begin
            p  = (k - 1) / div;
            ph = (k - 1) % div;
            h  = p % ht;
            v  = (p / ht) % vt;
            f  = p / (ht * vt);
            e.hpos = 10'(h);
            e.vpos = 10'(v);
            e.hsync = (h >= hd + hf && h < hd + hf + hs) ? act : ~act;
            e.vsync = (v >= vd + vf && v < vd + vf + vs) ? act : ~act;
            e.display_on = (h < hd) && (v < vd);
            e.line_start = (ph == 0) && (h == 0);
            e.frame_start = (ph == 0) && (h == 0) && (v == 0);
            e.frame_cnt = 8'((f + 1) % 256);
        end
        return e;
    endfunction

    task automatic push(input int i, input obs_t e);
        case (i)
            0: q_a.push_back(e);
            1: q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic set_rst(input int i, input logic val);
        case (i)
            0: rst_a = val;
            1: rst_b = val;
            default: rst_c = val;
        endcase
    endtask

    task automatic check(input string nm, input obs_t a, input obs_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s t=%0t got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d want h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
                     nm, $time, a.hpos, a.vpos, a.hsync, a.vsync, a.display_on, a.line_start, a.frame_start, a.frame_cnt,
                     e.hpos, e.vpos, e.hsync, e.vsync, e.display_on, e.line_start, e.frame_start, e.frame_cnt);
        end
    endtask

    // Reset for 5 clks, run n clks; optionally assert reset between edges and rerun n2 clks
    task automatic run_inst(input int i, input int n, input bit mid_rst, input int n2);
        set_rst(i, 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
            push(i, model(i, 0));
        end
        set_rst(i, 1'b1);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            push(i, model(i, k));
        end
        if (mid_rst) begin
            @(posedge clk); #2;
            set_rst(i, 1'b0);
            push(i, model(i, 0));
            repeat (3) begin
                @(posedge clk); #1;
                push(i, model(i, 0));
            end
            set_rst(i, 1'b1);
            for (int k = 1; k <= n2; k++) begin
                @(posedge clk); #1;
                push(i, model(i, k));
            end
        end
    endtask

    // Monitors: compare every presented cycle against the queued expectation
    always @(negedge clk) if (q_a.size() > 0) check("small_pos_pol", obs_a, q_a.pop_front());
    always @(negedge clk) if (q_b.size() > 0) check("clk_div2", obs_b, q_b.pop_front());
    always @(negedge clk) if (q_c.size() > 0) check("default_vga", obs_c, q_c.pop_front());

    initial begin
        fork
            run_inst(0, 300 * 48 + 20, 1'b0, 0);
            run_inst(1, 3 * 240 + 10, 1'b1, 250);
            run_inst(2, 2 * 800 + 300, 1'b1, 900);
        join
        @(negedge clk); #1;
        total++;
        if (q_a.size() + q_b.size() + q_c.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", q_a.size() + q_b.size() + q_c.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL timeout got running want finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
